// File: rtl/mac_ativacao.sv
`default_nettype none
// ============================================================================
// Module  : mac_ativacao
// Purpose : Neuron activation stage that follows the layer MAC. It captures
//           the MAC's saturated Q21.10 sum when the done flag is first seen.
//           It then applies a linear, ReLU or piecewise-linear sigmoid
//           activation and presents a signed Q2.5 byte to the next layer.
// Ports   : clkAtiv  - clock, rising edge
//           start    - async active-high reset; also re-arms for next neuron
//           iSoma    - signed Q21.10 sum from the MAC
//           iSomaOK  - MAC done flag, level-held until start
//           iModo    - 00 linear, 01 ReLU, 10 sigmoid, 11 linear
//           oAtiv    - signed Q2.5 activation output
//           oAtivOK  - oAtiv valid, held until start
// Revision: 1.0 - initial release
// ============================================================================
module mac_ativacao (
  input  logic               clkAtiv,
  input  logic               start,
  input  logic signed [31:0] iSoma,
  input  logic               iSomaOK,
  input  logic        [1:0]  iModo,
  output logic        [7:0]  oAtiv,
  output logic               oAtivOK
);

  localparam logic [1:0] MODE_RELU    = 2'b01;
  localparam logic [1:0] MODE_SIGMOID = 2'b10;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ABS  = 3'd1,
    SEG  = 3'd2,
    OUT  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t state, state_next;

  logic signed [31:0] soma_q;
  logic        [1:0]  modo_q;
  logic               sign_q;
  logic        [30:0] abs_q;
  logic        [10:0] y_q;

  logic        [30:0] abs_val;
  logic        [10:0] y_val;
  logic        [10:0] sig_pre;
  logic        [7:0]  sig_out;
  logic signed [31:0] lin_shift;
  logic        [7:0]  lin_out;
  logic        [7:0]  act_val;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clkAtiv or posedge start) begin
    if (start) state <= IDLE;
    else       state <= state_next;
  end

  // --------------------------------------------------------------------------
  // Next-state logic; DONE is terminal until start re-arms the block, so a
  // level-held iSomaOK cannot produce a second result.
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (iSomaOK) state_next = ABS;
      ABS:     state_next = SEG;
      SEG:     state_next = OUT;
      OUT:     state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath combinational logic
  // --------------------------------------------------------------------------
  always_comb begin
    // |x|; the most negative sum has no positive twin, so it clamps.
    abs_val = '0;
    if (soma_q == 32'sh8000_0000)
      abs_val = 31'h7FFF_FFFF;
    else if (soma_q[31])
      abs_val = 31'(-soma_q);
    else
      abs_val = soma_q[30:0];

    // Piecewise sigmoid in Q.10. Each branch only sees |x| below its upper
    // bound, so the narrow slices below carry every significant bit.
    y_val = '0;
    if (abs_q >= 31'd5120)
      y_val = 11'd1024;
    else if (abs_q >= 31'd2432)
      y_val = {3'b000, abs_q[12:5]} + 11'd864;
    else if (abs_q >= 31'd1024)
      y_val = {2'b00, abs_q[11:3]} + 11'd640;
    else
      y_val = {3'b000, abs_q[9:2]} + 11'd512;

    // Negative side uses sigmoid symmetry: s(-x) = 1 - s(x).
    sig_pre = sign_q ? (11'd1024 - y_q) : y_q;
    sig_out = 8'(sig_pre >> 5);

    // Q.10 to Q.5 with floor, then clamp to the signed byte range.
    lin_shift = soma_q >>> 5;
    lin_out   = '0;
    if (lin_shift > 32'sd127)
      lin_out = 8'h7F;
    else if (lin_shift < -32'sd128)
      lin_out = 8'h80;
    else
      lin_out = lin_shift[7:0];

    act_val = '0;
    case (modo_q)
      MODE_SIGMOID: act_val = sig_out;
      MODE_RELU:    act_val = soma_q[31] ? 8'h00 : lin_out;
      default:      act_val = lin_out;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers; inputs are only looked at while in IDLE.
  // --------------------------------------------------------------------------
  always_ff @(posedge clkAtiv or posedge start) begin
    if (start) begin
      soma_q  <= '0;
      modo_q  <= '0;
      sign_q  <= 1'b0;
      abs_q   <= '0;
      y_q     <= '0;
      oAtiv   <= 8'h00;
      oAtivOK <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iSomaOK) begin
            soma_q <= iSoma;
            modo_q <= iModo;
          end
        end
        ABS: begin
          sign_q <= soma_q[31];
          abs_q  <= abs_val;
        end
        SEG: begin
          y_q <= y_val;
        end
        OUT: begin
          oAtiv   <= act_val;
          oAtivOK <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mac_ativacao.sv
`default_nettype none
// ============================================================================
// Module  : tb_mac_ativacao
// Purpose : Directed vector bench for mac_ativacao.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mac_ativacao;

  logic        clkAtiv;
  logic        start;
  logic [31:0] iSoma;
  logic        iSomaOK;
  logic [1:0]  iModo;
  logic [7:0]  oAtiv;
  logic        oAtivOK;

  int n_vec  = 0;
  int n_fail = 0;

  mac_ativacao dut (
    .clkAtiv (clkAtiv),
    .start   (start),
    .iSoma   (iSoma),
    .iSomaOK (iSomaOK),
    .iModo   (iModo),
    .oAtiv   (oAtiv),
    .oAtivOK (oAtivOK)
  );

  initial clkAtiv = 1'b0;
  always #5 clkAtiv = ~clkAtiv;

  typedef struct {
    logic [31:0] soma;
    logic [1:0]  modo;
    logic [7:0]  expv;
  } vec_t;

  vec_t vecs[18];

  task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b", name, got, want);
    end
  endtask

  // Pulse start, present the sum with iSomaOK on the first edge after start
  // falls, scramble inputs after capture, and check the 3-edge latency.
  task automatic run_neuron(input logic [31:0] soma, input logic [1:0] modo,
                            input logic [7:0] expv, input string name);
    start   = 1'b1;
    iSomaOK = 1'b0;
    #1;
    chk1({name, " rst ok"}, oAtivOK, 1'b0);
    chk8({name, " rst val"}, oAtiv, 8'h00);
    @(posedge clkAtiv); #1;
    start   = 1'b0;
    iSoma   = soma;
    iModo   = modo;
    iSomaOK = 1'b1;
    @(posedge clkAtiv); #1;              // capture edge k
    iSoma = ~soma;
    iModo = modo ^ 2'b10;
    chk1({name, " ok@k"}, oAtivOK, 1'b0);
    @(posedge clkAtiv); #1;
    chk1({name, " ok@k+1"}, oAtivOK, 1'b0);
    @(posedge clkAtiv); #1;
    chk1({name, " ok@k+2"}, oAtivOK, 1'b0);
    @(posedge clkAtiv); #1;
    chk1({name, " ok@k+3"}, oAtivOK, 1'b1);
    chk8({name, " val"}, oAtiv, expv);
  endtask

  initial begin
    vecs[0]  = '{32'h0000_0000, 2'b10, 8'h10};  // sigmoid 0
    vecs[1]  = '{32'h0000_0400, 2'b10, 8'h18};  // sigmoid +1.0
    vecs[2]  = '{32'hFFFF_FC00, 2'b10, 8'h08};  // sigmoid -1.0
    vecs[3]  = '{32'h0000_1800, 2'b10, 8'h20};  // sigmoid +6.0
    vecs[4]  = '{32'hFFFF_E800, 2'b10, 8'h00};  // sigmoid -6.0
    vecs[5]  = '{32'h0000_0980, 2'b10, 8'h1D};  // 2.375: (76+864)>>5 = 29
    vecs[6]  = '{32'h8000_0000, 2'b10, 8'h00};  // abs saturation
    vecs[7]  = '{32'h0000_097F, 2'b10, 8'h1C};  // just below: (303+640)>>5 = 29? -> 943>>5=29
    vecs[8]  = '{32'h0000_1400, 2'b10, 8'h20};  // 5.0 exactly -> 1024
    vecs[9]  = '{32'h0000_0600, 2'b00, 8'h30};  // linear 1.5
    vecs[10] = '{32'h0000_2800, 2'b00, 8'h7F};  // linear +10 clamp
    vecs[11] = '{32'hFFFF_D800, 2'b00, 8'h80};  // linear -10 clamp
    vecs[12] = '{32'hFFFF_F400, 2'b01, 8'h00};  // ReLU -3
    vecs[13] = '{32'h0000_0600, 2'b01, 8'h30};  // ReLU 1.5
    vecs[14] = '{32'hFFFF_FFFF, 2'b11, 8'hFF};  // mode 11 linear, floor -> -1
    vecs[15] = '{32'h0000_0FE0, 2'b00, 8'h7F};  // 4064>>5 = 127 exact
    vecs[16] = '{32'hFFFF_F000, 2'b00, 8'h80};  // -4096>>5 = -128 exact
    vecs[17] = '{32'h0000_0020, 2'b01, 8'h01};  // ReLU smallest positive
    // 0x97F = 2431: (2431>>3)=303, +640 = 943, >>5 = 29 = 0x1D
    vecs[7].expv = 8'h1D;

    start   = 1'b1;
    iSoma   = '0;
    iSomaOK = 1'b0;
    iModo   = '0;
    repeat (3) @(posedge clkAtiv);
    #1;
    chk1("reset ok", oAtivOK, 1'b0);
    chk8("reset val", oAtiv, 8'h00);

    // Outputs stay cleared while start is held, even with iSomaOK high.
    iSomaOK = 1'b1;
    iSoma   = 32'h0000_0400;
    iModo   = 2'b10;
    repeat (4) begin
      @(posedge clkAtiv); #1;
      chk1("start held ok", oAtivOK, 1'b0);
    end

    for (int i = 0; i < 18; i++)
      run_neuron(vecs[i].soma, vecs[i].modo, vecs[i].expv, $sformatf("vec%0d", i));

    // Hold: iSomaOK stays high while inputs wander; result must not move.
    for (int i = 0; i < 20; i++) begin
      iSoma   = $urandom;
      iModo   = 2'($urandom_range(0, 3));
      iSomaOK = 1'b1;
      @(posedge clkAtiv); #1;
      chk8("hold val", oAtiv, 8'h01);
      chk1("hold ok", oAtivOK, 1'b1);
    end

    // Abort during SEG.
    start   = 1'b1;
    iSomaOK = 1'b0;
    @(posedge clkAtiv); #1;
    start   = 1'b0;
    iSoma   = 32'h0000_1800;
    iModo   = 2'b10;
    iSomaOK = 1'b1;
    @(posedge clkAtiv); #1;               // capture -> ABS
    @(posedge clkAtiv); #1;               // now SEG
    start = 1'b1;
    #1;
    chk1("abort ok", oAtivOK, 1'b0);
    chk8("abort val", oAtiv, 8'h00);
    repeat (4) begin
      @(posedge clkAtiv); #1;
      chk1("abort held ok", oAtivOK, 1'b0);
      chk8("abort held val", oAtiv, 8'h00);
    end

    // Fresh results after the abort, back to back.
    run_neuron(32'h0000_0400, 2'b10, 8'h18, "post abort");
    run_neuron(32'hFFFF_FC00, 2'b10, 8'h08, "b2b a");
    run_neuron(32'h0000_0600, 2'b00, 8'h30, "b2b b");

    // Abort from DONE clears a nonzero result immediately.
    start = 1'b1;
    #1;
    chk8("done abort val", oAtiv, 8'h00);
    chk1("done abort ok", oAtivOK, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mac_ativacao.md
MAC_ATIVACAO -- requirements
Module: mac_ativacao

Purpose: neuron activation stage placed directly downstream of the layer MAC. It consumes the MAC's 32-bit saturated sum and done flag, and produces the 8-bit neuron output in the format the next layer takes as input.

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high, named start as in the layer MAC.
REQ-002 clkAtiv  input  1  clock; all state SHALL update on its rising edge.
REQ-003 start  input  1  async active-high reset; also re-arms the block for the next neuron, exactly as for the MAC.
REQ-004 iSoma  input  32  signed Q21.10 sum from the MAC (oSoma).
REQ-005 iSomaOK  input  1  MAC done flag (oSomaOK); level-held high until start.
REQ-006 iModo  input  2  activation select: 00 linear, 01 ReLU, 10 sigmoid (PLAN), 11 linear.
REQ-007 oAtiv  output  8  signed Q2.5 neuron output, range -4.0..3.96875.
REQ-008 oAtivOK  output  1  high when oAtiv is valid; held until start.

Function
REQ-009 The FSM SHALL have five states: IDLE, ABS, SEG, OUT, DONE.
REQ-010 Transitions SHALL be:
- IDLE to ABS on the first rising edge that samples iSomaOK=1.
- ABS to SEG, SEG to OUT and OUT to DONE unconditionally.
- DONE to DONE until start.
REQ-011 At the IDLE-to-ABS edge the block SHALL register iSoma and iModo; later changes on either input SHALL NOT affect the result.
REQ-012 In ABS the block SHALL register the sign flag (iSoma[31]) and |x|; |x| of -2^31 SHALL saturate to 2^31-1.
REQ-013 In SEG, for sigmoid, the block SHALL compute y in Q.10 from |x| with truncating right shifts:
- |x| >= 5.0 (5120): y = 1024.
- 2.375 <= |x| < 5.0 (2432..5119): y = (|x|>>5) + 864.
- 1.0 <= |x| < 2.375 (1024..2431): y = (|x|>>3) + 640.
- |x| < 1.0: y = (|x|>>2) + 512.
REQ-014 In OUT, sigmoid SHALL use y if the sign flag is 0, otherwise 1024 - y, then arithmetic shift right by 5. The result (0..32) SHALL go to oAtiv.
REQ-015 Linear SHALL form the signed sum arithmetic-shifted right by 5 (floor) and saturate it to [-128, 127].
REQ-016 ReLU SHALL output 0 for a negative sum; otherwise it SHALL behave as linear.
REQ-017 In OUT, oAtiv and oAtivOK<=1 SHALL be registered. Latency: if iSomaOK is first sampled at edge k, both outputs SHALL be valid after edge k+3.
REQ-018 In DONE, oAtiv and oAtivOK SHALL hold. iSomaOK, iSoma and iModo SHALL be ignored from ABS until the next start.
REQ-019 Exactly one result SHALL be produced per start; a level-held iSomaOK SHALL NOT retrigger.
REQ-020 If iSomaOK is already 1 on the first edge after start deasserts, capture SHALL occur on that edge.
REQ-021 All arithmetic SHALL be signed two's complement. Intermediate widths SHALL be sufficient that no wrap occurs before saturation.

Reset
REQ-022 When start is asserted, asynchronously: FSM to IDLE, oAtiv=8'h00, oAtivOK=0, and all internal registers cleared.
REQ-023 Assertion of start in ABS, SEG, OUT or DONE SHALL abort immediately. No partial result SHALL appear on oAtiv.
REQ-024 The outputs SHALL remain at reset values while start is high, regardless of iSomaOK.

Verification
REQ-025 Sigmoid values; each checks oAtivOK=1 exactly 3 edges after the capture edge:

| iSoma | oAtiv |
|---|---|
| 0x00000000 | 0x10 |
| 0x00000400 (+1.0) | 0x18 |
| 0xFFFFFC00 (-1.0) | 0x08 |
| 0x00001800 (+6.0) | 0x20 |
| 0xFFFFE800 (-6.0) | 0x00 |

REQ-026 Sigmoid at the segment boundary, iSoma=0x00000980 (2.375) -> oAtiv=0x1D (29). Also iSoma=0x80000000 -> oAtiv=0x00 (abs saturation path).
REQ-027 Linear and ReLU values:

| Mode | iSoma | oAtiv |
|---|---|---|
| Linear | 0x00000600 (1.5) | 0x30 |
| Linear | 0x00002800 (10.0) | 0x7F |
| Linear | 0xFFFFD800 (-10.0) | 0x80 |
| ReLU | 0xFFFFF400 (-3.0) | 0x00 |
| ReLU | 0x00000600 | 0x30 |

REQ-028 Hold behaviour: keep iSomaOK=1 for 20 cycles after DONE and change iSoma and iModo. oAtiv SHALL be unchanged and oAtivOK SHALL stay 1 with no retrigger.
REQ-029 Reset mid-operation: pulse start during SEG -> oAtiv=0x00 and oAtivOK=0 immediately. A new iSomaOK then produces a fresh result with full latency.
REQ-030 Back-to-back neurons: start, result, start, result, with the next iSomaOK on the first edge after start -> each result is correct and its latency is 3 edges.
